// File: rtl/pixel_buf_pkg.sv
// Shared sizes and types for the pixel buffer controller and its read FIFO.
package pixel_buf_pkg;
   localparam int PIX_DEPTH = 1024;
   localparam int PIX_AW    = 10;
   localparam int PIX_LANES = 3;
   localparam int PIX_PW    = 16;

   typedef logic [PIX_LANES*PIX_PW-1:0] pix_word_t;
   typedef logic [PIX_AW-1:0]           pix_addr_t;
endpackage

// File: rtl/pixel_rd_fifo.sv
// Two-entry FIFO with occupancy count; simultaneous push and pop keep order.
// The caller guarantees no push into a full FIFO unless it pops in the same cycle.
module pixel_rd_fifo
   import pixel_buf_pkg::*;
#(
   parameter int W = $bits(pix_word_t)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic [1:0]   count_o
);
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, rd_ptr_q;
   logic [1:0]   cnt_q, cnt_d;

   assign cnt_d   = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

   // Pointer and count state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_i) wr_ptr_q <= ~wr_ptr_q;
         if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_d;
      end
   end

   // Data storage needs no reset; the count masks stale entries.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end
endmodule

// File: rtl/pixel_buf_ctrl.sv
// Pixel SRAM initiator: port A writes a pixel stream lane by lane, port B serves
// word reads through a 2-entry FIFO. A and B are never equal while writing.
// Optional macro PIXEL_BUF_HAZARD_CNT_EN adds a saturating hazard_cnt output.
module pixel_buf_ctrl
   import pixel_buf_pkg::*;
#(
   parameter int DEPTH = PIX_DEPTH,
   parameter int AW    = PIX_AW,
   parameter int LANES = PIX_LANES,
   parameter int PW    = PIX_PW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PW-1:0]       in_data,
   input  logic                rd_req_valid,
   output logic                rd_req_ready,
   input  logic [AW-1:0]       rd_req_addr,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [LANES*PW-1:0] rd_data,
   output logic [AW:0]         words_done,
   output logic                wr_wrap,
   output logic                OEA,
   output logic                OEB,
   output logic [LANES-1:0]    WEAN,
   output logic [LANES-1:0]    WEBN,
   output logic [AW-1:0]       A,
   output logic [AW-1:0]       B,
   output logic [LANES*PW-1:0] DIA,
   output logic [LANES*PW-1:0] DIB,
   input  logic [LANES*PW-1:0] DOB
`ifdef PIXEL_BUF_HAZARD_CNT_EN
   ,output logic [15:0]        hazard_cnt
`endif
);
   localparam int LPW = (LANES > 1) ? $clog2(LANES) : 1;

   logic [LPW-1:0] lane_ptr_q, lane_ptr_d;
   logic [AW-1:0]  wr_addr_q, wr_addr_d;
   logic [AW:0]    words_done_q, words_done_d;
   logic           wr_wrap_q, wr_wrap_d;
   logic [AW-1:0]  b_q, b_d;
   logic           outstanding_q;
   logic           wr_acc, word_end, addr_last;
   logic           hazard, rd_acc, pop;
   logic [1:0]     fifo_cnt;
   logic [2:0]     occ;

   // ---------------- write path ----------------
   assign in_ready  = ~frame_start;
   assign wr_acc    = in_valid & in_ready;
   assign word_end  = wr_acc & (lane_ptr_q == LPW'(LANES-1));
   assign addr_last = (wr_addr_q == AW'(DEPTH-1));

   assign A    = wr_addr_q;
   assign DIA  = {LANES{in_data}};
   assign WEAN = wr_acc ? ~(LANES'(1) << lane_ptr_q) : {LANES{1'b1}};
   assign OEA  = 1'b0;
   assign WEBN = {LANES{1'b1}};
   assign DIB  = '0;
   assign words_done = words_done_q;
   assign wr_wrap    = wr_wrap_q;

   // Next write position; frame_start abandons any partial word.
   always_comb begin
      lane_ptr_d   = lane_ptr_q;
      wr_addr_d    = wr_addr_q;
      words_done_d = words_done_q;
      wr_wrap_d    = word_end & addr_last;
      if (frame_start) begin
         lane_ptr_d   = '0;
         wr_addr_d    = '0;
         words_done_d = '0;
      end else if (word_end) begin
         lane_ptr_d = '0;
         wr_addr_d  = addr_last ? '0 : wr_addr_q + 1'b1;
         if (words_done_q < (AW+1)'(DEPTH)) words_done_d = words_done_q + 1'b1;
      end else if (wr_acc) begin
         lane_ptr_d = lane_ptr_q + 1'b1;
      end
   end

   // Write-side state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_ptr_q   <= '0;
         wr_addr_q    <= '0;
         words_done_q <= '0;
         wr_wrap_q    <= 1'b0;
      end else begin
         lane_ptr_q   <= lane_ptr_d;
         wr_addr_q    <= wr_addr_d;
         words_done_q <= words_done_d;
         wr_wrap_q    <= wr_wrap_d;
      end
   end

   // ---------------- read path ----------------
   // A pop in the current cycle frees its slot immediately so that a held
   // rd_ready sustains one word per cycle.
   assign pop          = rd_valid & rd_ready;
   assign occ          = 3'(fifo_cnt) + 3'(outstanding_q) - 3'(pop);
   assign hazard       = wr_acc & (rd_req_addr == wr_addr_q);
   assign rd_req_ready = (occ < 3'd2) & ~hazard;
   assign rd_acc       = rd_req_valid & rd_req_ready;
   assign rd_valid     = (fifo_cnt != 2'd0);
   assign OEB          = rd_acc;
   assign B            = b_d;

   // B follows an issued read; on a write-only cycle it moves off A.
   always_comb begin
      b_d = b_q;
      if (rd_acc)      b_d = rd_req_addr;
      else if (wr_acc) b_d = ~wr_addr_q;
   end

   // Read-issue state; reset drops any read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q           <= '0;
         outstanding_q <= 1'b0;
      end else begin
         b_q           <= b_d;
         outstanding_q <= rd_acc;
      end
   end

   pixel_rd_fifo #(.W(LANES*PW)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (outstanding_q),
      .pop_i  (pop),
      .din_i  (DOB),
      .dout_o (rd_data),
      .count_o(fifo_cnt)
   );

`ifdef PIXEL_BUF_HAZARD_CNT_EN
   logic [15:0] hz_cnt_q;
   assign hazard_cnt = hz_cnt_q;

   // Saturating count of cycles where a valid read is stalled by a write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                        hz_cnt_q <= '0;
      else if (frame_start)                              hz_cnt_q <= '0;
      else if (hazard & rd_req_valid & ~(&hz_cnt_q))     hz_cnt_q <= hz_cnt_q + 1'b1;
   end
`endif
endmodule

// File: tb/tb_pixel_buf_ctrl.sv
// Self-checking bench for pixel_buf_ctrl with a behavioural SRAM and a
// scoreboard fed from a pixel-index based reference model.
module tb_pixel_buf_ctrl;
   import pixel_buf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0, in_valid = 1'b0, rd_req_valid = 1'b0, rd_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic [9:0]  rd_req_addr = '0;
   logic        in_ready, rd_req_ready, rd_valid, wr_wrap, OEA, OEB;
   logic [47:0] rd_data, DIA, DIB;
   logic [47:0] dob = '0;
   logic [10:0] words_done;
   logic [2:0]  WEAN, WEBN;
   logic [9:0]  A, B;
`ifdef PIXEL_BUF_HAZARD_CNT_EN
   logic [15:0] hazard_cnt;
`endif

   always #5 clk = ~clk;

   pixel_buf_ctrl dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .words_done(words_done), .wr_wrap(wr_wrap),
      .OEA(OEA), .OEB(OEB), .WEAN(WEAN), .WEBN(WEBN), .A(A), .B(B),
      .DIA(DIA), .DIB(DIB), .DOB(dob)
`ifdef PIXEL_BUF_HAZARD_CNT_EN
      , .hazard_cnt(hazard_cnt)
`endif
   );

   // Behavioural dual-port SRAM: lane writes on A, registered read on B.
   logic [47:0] sram [PIX_DEPTH] = '{default: '0};
   always @(posedge clk) begin
      for (int l = 0; l < 3; l++)
         if (!WEAN[l]) sram[A][l*16 +: 16] <= DIA[l*16 +: 16];
      if (OEB) dob <= sram[B];
   end

   int nvec = 0, nerr = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: pixel k since frame_start lands in word (k/3)%DEPTH, lane k%3.
   logic [47:0] ref_mem [PIX_DEPTH] = '{default: '0};
   logic [47:0] expq [$];
   int          pix_cnt = 0, wrap_seen = 0, hz_model = 0;
   bit          exp_wrap = 0;
   bit          wacc, pop_s, hz, mdl_rdy;
   int          waddr, lane, wd, occ;
   logic [2:0]  ewe;
   logic [47:0] e;

   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         exp_wrap = 0; pix_cnt = 0; hz_model = 0;
      end else begin
         wacc    = in_valid && !frame_start;
         waddr   = (pix_cnt / 3) % PIX_DEPTH;
         lane    = pix_cnt % 3;
         wd      = (pix_cnt / 3 > PIX_DEPTH) ? PIX_DEPTH : pix_cnt / 3;
         pop_s   = rd_valid && rd_ready;
         hz      = wacc && (int'(rd_req_addr) == waddr);
         occ     = expq.size() - (pop_s ? 1 : 0);
         mdl_rdy = (occ < 2) && !hz;
         ewe     = wacc ? ~(3'b001 << lane) : 3'b111;
         chk("in_ready", in_ready, !frame_start);
         chk("A", A, waddr);
         chk("WEAN", WEAN, ewe);
         if (wacc) chk("DIA", DIA, {3{in_data}});
         chk("words_done", words_done, wd);
         chk("wr_wrap", wr_wrap, exp_wrap);
         chk("rd_req_ready", rd_req_ready, mdl_rdy);
         chk("OEB", OEB, rd_req_valid && mdl_rdy);
         if (OEB) chk("B_issue", B, rd_req_addr);
         if (WEAN != 3'b111) chk("A_ne_B", A != B, 1);
`ifdef PIXEL_BUF_HAZARD_CNT_EN
         chk("hazard_cnt", hazard_cnt, hz_model);
         if (frame_start) hz_model = 0;
         else if (hz && rd_req_valid && hz_model < 65535) hz_model++;
`endif
         if (pop_s) begin
            if (expq.size() == 0) chk("rd_valid_spurious", 1, 0);
            else begin
               e = expq.pop_front();
               chk("rd_data", rd_data, e);
            end
         end
         if (rd_req_valid && rd_req_ready) expq.push_back(ref_mem[rd_req_addr]);
         if (wr_wrap) wrap_seen++;
         exp_wrap = wacc && lane == 2 && waddr == PIX_DEPTH - 1;
         if (frame_start) pix_cnt = 0;
         else if (wacc) begin
            ref_mem[waddr][lane*16 +: 16] = in_data;
            pix_cnt++;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int acc, got, ws0;
   initial begin
      // Reset state.
      idle(2);
      @(negedge clk);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_WEAN", WEAN, 3'b111);
      chk("rst_OEB", OEB, 0);
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_words_done", words_done, 0);
      chk("rst_wr_wrap", wr_wrap, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(1);

      // Six pixels -> two words.
      for (int i = 1; i <= 6; i++) begin in_valid = 1; in_data = 16'(i); idle(1); end
      in_valid = 0;
      @(negedge clk); chk("words_done_2", words_done, 2);
      @(posedge clk); #1;

      // Back-to-back reads of words 0 and 1, exact latency and data.
      rd_ready = 1; rd_req_valid = 1; rd_req_addr = 0;
      @(negedge clk); chk("rd0_accept", rd_req_ready, 1);
      @(posedge clk); #1 rd_req_addr = 1;
      @(negedge clk); chk("rd1_accept", rd_req_ready, 1);
      chk("rd_valid_N+1", rd_valid, 0);
      @(posedge clk); #1 rd_req_valid = 0;
      @(negedge clk); chk("rd_valid_N+2", rd_valid, 1);
      chk("word0", rd_data, 48'h0003_0002_0001);
      @(negedge clk); chk("rd_valid_N+3", rd_valid, 1);
      chk("word1", rd_data, 48'h0006_0005_0004);
      @(posedge clk); #1; idle(3);

      // Backpressure: only two reads fit while rd_ready is low.
      rd_ready = 0; rd_req_valid = 1; rd_req_addr = 0; acc = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); if (rd_req_ready) acc++;
         @(posedge clk); #1;
         rd_req_addr = (acc == 1) ? 10'd1 : 10'd0;
      end
      chk("bp_accepts", acc, 2);
      @(negedge clk); chk("bp_ready_low", rd_req_ready, 0);
      @(posedge clk); #1 rd_ready = 1; got = 0;
      for (int k = 0; k < 10 && got == 0; k++) begin
         @(negedge clk); if (rd_req_ready) got = 1;
         @(posedge clk); #1;
      end
      chk("bp_third_accepted", got, 1);
      rd_req_valid = 0; idle(4);

      // Hazard: read the word currently being written.
      in_valid = 1; rd_req_valid = 1; rd_req_addr = 10'((pix_cnt / 3) % PIX_DEPTH); got = -1;
      for (int k = 0; k < 8 && got < 0; k++) begin
         in_data = 16'($urandom);
         @(negedge clk); if (rd_req_ready) got = k;
         @(posedge clk); #1;
      end
      in_valid = 0; rd_req_valid = 0;
      chk("hazard_stall_cycles", got, 3);
      idle(4);

      // Randomised traffic.
      for (int k = 0; k < 600; k++) begin
         in_valid     = ($urandom % 4) != 0;
         in_data      = 16'($urandom);
         rd_req_valid = $urandom % 2;
         rd_req_addr  = ($urandom % 4 == 0) ? 10'((pix_cnt / 3) % PIX_DEPTH) : 10'($urandom % 16);
         rd_ready     = ($urandom % 10) < 7;
         frame_start  = ($urandom % 64) == 0;
         idle(1);
      end
      in_valid = 0; rd_req_valid = 0; frame_start = 0; rd_ready = 1;
      idle(6);

      // Full-depth stream: one wrap, words_done saturates.
      frame_start = 1; idle(1); frame_start = 0;
      ws0 = wrap_seen;
      for (int k = 0; k < 3 * PIX_DEPTH; k++) begin in_valid = 1; in_data = 16'($urandom); idle(1); end
      in_valid = 0; idle(2);
      chk("wrap_count", wrap_seen - ws0, 1);
      @(negedge clk);
      chk("words_done_full", words_done, PIX_DEPTH);
      chk("A_after_wrap", A, 0);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin in_valid = 1; in_data = 16'($urandom); idle(1); end
      in_valid = 0;
      @(negedge clk); chk("words_done_sat", words_done, PIX_DEPTH);
      @(posedge clk); #1;

      // frame_start mid-word abandons the partial word.
      frame_start = 1; idle(1); frame_start = 0;
      for (int k = 0; k < 2; k++) begin in_valid = 1; in_data = 16'(k + 16'h10); idle(1); end
      frame_start = 1;
      @(negedge clk); chk("fs_in_ready", in_ready, 0);
      chk("fs_WEAN", WEAN, 3'b111);
      @(posedge clk); #1 frame_start = 0; in_data = 16'hABCD;
      @(negedge clk);
      chk("fs_lane0", WEAN, 3'b110);
      chk("fs_A0", A, 0);
      chk("fs_words_done", words_done, 0);
      @(posedge clk); #1 in_valid = 0;
      idle(2);

      // Reset with a read in flight: nothing is pushed afterwards.
      rd_ready = 1; rd_req_valid = 1; rd_req_addr = 10'd5;
      idle(1);
      rd_req_valid = 0; rst_n = 0;
      idle(2);
      rst_n = 1;
      for (int k = 0; k < 4; k++) begin @(negedge clk); chk("rst_drop_rd_valid", rd_valid, 0); end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/pixel_buf_ctrl.md
Name: pixel_buf_ctrl

Overview:
- Initiator that drives the pixel SRAM wrapper (1024 words x 48 bit, 3 lanes of 16 bit, dual port, active-low per-lane write enables).
- Port A is write-only: an incoming 16-bit pixel stream is written lane-by-lane into consecutive words.
- Port B is read-only: word read requests return 48-bit data through a 2-entry output FIFO with backpressure.
- The block never presents equal A/B addresses in the same cycle, so the wrapper's collision remap never fires.

Parameters:
- DEPTH, 1024, SRAM words
- AW, 10, address width (clog2 DEPTH)
- LANES, 3, pixels per word
- PW, 16, pixel width

Ports:
- clk  in  1  clock; also drives the wrapper CK
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  sync pulse; clears write pointers and word count
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid & in_ready
- in_data  in  PW  pixel
- rd_req_valid  in  1  read request
- rd_req_ready  out  1  request accepted when both high
- rd_req_addr  in  AW  word address
- rd_valid  out  1  read data valid
- rd_ready  in  1  consumer ready
- rd_data  out  LANES*PW  read word
- words_done  out  AW+1  completed words since frame_start, saturates at DEPTH
- wr_wrap  out  1  1-cycle pulse when the write address wraps DEPTH-1 -> 0
- OEA  out  1  tied 0
- OEB  out  1  high in read-issue cycles
- WEAN  out  LANES  active-low lane write enables
- WEBN  out  LANES  tied all-ones
- A  out  AW  write address
- B  out  AW  read address
- DIA  out  LANES*PW  write data
- DIB  out  LANES*PW  tied 0
- DOB  in  LANES*PW  port B read data, valid the cycle after issue

Behaviour:
- Reset values: wr_addr=0, lane_ptr=0, words_done=0, FIFO empty, outstanding=0, rd_valid=0, wr_wrap=0, WEAN=all-ones, OEB=0, A=0, B=0. rd_data is don't-care while rd_valid=0.
- Write path:
  - On accept: WEAN = ~(1<<lane_ptr), DIA = {LANES{in_data}}, A = wr_addr. Combinational from state in the same cycle. WEAN=all-ones when no accept.
  - lane_ptr increments; at LANES-1 it returns to 0, wr_addr increments, and words_done increments (saturating at DEPTH).
  - At wr_addr=DEPTH-1 completing a word, wr_addr becomes 0 and wr_wrap pulses next cycle.
- in_ready = 1 except when frame_start=1. frame_start forces in_ready=0 that cycle and clears wr_addr, lane_ptr and words_done at the clock edge. A partial word is abandoned.
- Read path:
  - Credit = 2 - (FIFO count + outstanding).
  - rd_req_ready = (credit>0) & ~hazard.
  - On accept: B = rd_req_addr and OEB=1 that cycle; outstanding is set.
  - Next cycle, DOB is pushed into the FIFO. rd_valid is high from the following cycle.
  - Minimum latency: accept at cycle N -> rd_valid at N+2. Pop on rd_valid & rd_ready.
  - A simultaneous push and pop is allowed; order is preserved.
  - Sustained throughput is 1 word per cycle when rd_ready is held high.
- Hazard rule: hazard = in_valid & in_ready & (rd_req_addr == wr_addr). The write takes priority and the read stalls; rd_req_addr is re-compared next cycle.
- When no read is issued: B holds its last value and OEB=0. B must differ from A whenever WEAN != all-ones, so B is driven to ~wr_addr if a write occurs in a cycle with no read issue.
- Reading addresses beyond words_done is permitted and returns stale SRAM contents. No error is raised.
- Reset mid-operation: all state clears immediately. A read in flight is dropped and is not pushed.

Optional Feature:
- Macro: PIXEL_BUF_HAZARD_CNT_EN.
- When defined:
  - Extra output port hazard_cnt [15:0] counts cycles with hazard=1 and rd_req_valid=1.
  - The counter saturates at 16'hFFFF and is cleared by reset and by frame_start.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package pixel_buf_pkg holds: PIX_DEPTH=1024, PIX_AW=10, PIX_LANES=3, PIX_PW=16, typedef pix_word_t (logic [47:0]), typedef pix_addr_t (logic [9:0]).
- Sub-module pixel_rd_fifo: 2-entry FIFO with push/pop/count outputs, reusable for other buffers.
- The controller and the wrapper are instantiated side by side at the next level up.

Test Plan:
- Reset, then stream 6 pixels 16'h0001..0006 -> WEAN sequence 110,101,011,110,101,011; A=0,0,0,1,1,1; words_done=2.
- After writing words 0 and 1, read addr 0 then 1 back-to-back with rd_ready=1 -> rd_valid 2 cycles after first accept; rd_data = {0003,0002,0001}, then {0006,0005,0004}.
- Hold rd_ready=0 and issue 3 reads -> first 2 accepted, rd_req_ready low on third. Release -> data returns in order, third accepted next cycle.
- Drive a pixel write and rd_req_addr=wr_addr in the same cycle -> rd_req_ready=0, A != B every cycle, read accepted once the write address advances.
- Write 3*1024 pixels -> wr_wrap pulses once after the last lane of word 1023; A returns to 0; words_done=1024 and saturates.
- Assert frame_start after 2 pixels of a word -> in_ready=0 that cycle; next pixel writes lane 0 of word 0; words_done=0.
